// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scanner.
// Segment codes are active-high, bit0 = a through bit6 = g.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // True when digit idx and every more-significant digit are zero; digit0 is never a leading zero.
  // Codes 10..15 compare unequal to zero, so they stop the blanking run.
  function automatic logic lead_zero(input logic [15:0] digits, input logic [1:0] idx);
    logic all_zero;
    logic result;
    all_zero = 1'b1;
    result   = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      all_zero = all_zero & (digits[4*k +: 4] == 4'd0);
      if (idx == 2'(k)) result = all_zero;
    end
    return result;
  endfunction

endpackage

// File: rtl/seg7_scan4_if.sv
// Digit data in, scanned segment/anode drive out.
// master drives the digit data, slave is the scanner.
interface seg7_scan4_if;
  logic [15:0] i_digits;
  logic        i_load;
  logic        i_lzb;
  logic [6:0]  o_seg;
  logic [3:0]  o_an;

  modport master (output i_digits, i_load, i_lzb, input  o_seg, o_an);
  modport slave  (input  i_digits, i_load, i_lzb, output o_seg, o_an);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment driver with shadow register,
// scan prescaler and optional leading-zero blanking.
module seg7_scan4
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan4_if.slave  bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [3:0]    digit;
  logic [6:0]    seg_dec;
  logic [6:0]    seg_nxt;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          tick;

  assign tick  = (presc == PRESC_LAST);
  assign digit = shadow[{idx, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_dec)
  );

  assign seg_nxt = (bus.i_lzb && lead_zero(shadow, idx)) ? SEG_BLANK : seg_dec;

  // Outputs are decoded from the pre-edge index and shadow, giving one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 16'h0000;
      presc  <= '0;
      idx    <= 2'd0;
      an_q   <= 4'b0000;
      seg_q  <= SEG_BLANK;
    end else begin
      if (bus.i_load) shadow <= bus.i_digits;
      presc <= tick ? '0 : presc + 1'b1;
      idx   <= idx + 2'(tick);
      an_q  <= 4'b0001 << idx;
      seg_q <= seg_nxt;
    end
  end

  assign bus.o_an  = an_q;
  assign bus.o_seg = seg_q;

endmodule

// File: doc/seg7_scan4.md
SEG7_SCAN4 -- requirements
Module: seg7_scan4

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_digits  input  16  four BCD digits from cascaded counter10 stages; [3:0]=digit0 (units), [15:12]=digit3.
REQ-005 i_load  input  1  when high at an edge, i_digits is captured into the shadow register.
REQ-006 i_lzb  input  1  leading-zero blanking enable, sampled every cycle.
REQ-007 o_seg  output  7  segment drive, active-high, bit0=a .. bit6=g.
REQ-008 o_an  output  4  digit select, one-hot, active-high, bit k = digit k.

Function
REQ-009 Shadow register (16 bit) SHALL load i_digits on every edge with i_load=1 and hold otherwise; outputs SHALL never read i_digits directly.
REQ-010 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; the terminal tick is the cycle with count=SCAN_DIV-1.
REQ-011 Digit index (2 bit) SHALL advance 0->1->2->3->0 on each terminal tick; no other state changes it.
REQ-012 o_an and o_seg SHALL be registered: at each edge they take the values decoded from the index and shadow held before that edge (1-cycle latency).
REQ-013 o_an SHALL equal 1<<index when not in reset; exactly one bit set.
REQ-014 Decode: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, g..a); codes 10..15 SHALL display dash 40.
REQ-015 With i_lzb=1, digit k (k=3,2,1) SHALL be blanked (o_seg=00, o_an unchanged) if digit k and every higher digit equal 0; digit0 never blanked; with i_lzb=0 no blanking.
REQ-016 Invalid codes (10..15) count as non-zero for blanking.
REQ-017 i_load coinciding with a terminal tick: the index advance and shadow load both take effect at that edge; the next edge outputs the new index with the new shadow.
REQ-018 Latency from i_load sampled high to o_seg reflecting new data for the currently selected digit SHALL be 2 edges.

Reset
REQ-019 While rst=1 at an edge: shadow=0000, prescaler=0, index=0, o_an=0000, o_seg=00; rst dominates i_load.
REQ-020 First edge after rst deasserts: o_an=0001, o_seg=3F (i_lzb irrelevant, digit0 never blanked).
REQ-021 Reset asserted mid-scan SHALL restart the scan at digit0 with a full SCAN_DIV period.

Structure
REQ-022 Package seg7_pkg SHALL hold the ten digit segment constants, the dash and blank constants, and the digit count (4).
REQ-023 Combinational sub-module bcd_to_seg7 (4-bit in, 7-bit out, REQ-014 table) SHALL be instantiated once, fed by the index-selected shadow digit.
REQ-024 No latches, no gated or derived clocks; prescaler width = clog2(SCAN_DIV).

Verification (bench uses SCAN_DIV=4)
REQ-025 Reset 3 cycles, i_digits=1234, i_load pulse 1 cycle, i_lzb=0 -> o_an sequence 0001,0010,0100,1000 each held 4 cycles, o_seg 66,4F,5B,06 per digit.
REQ-026 Load 0007, i_lzb=1 -> digit0 o_seg=07; digits 1..3 o_seg=00 while o_an still cycles.
REQ-027 Load 0107, i_lzb=1 -> digit1 o_seg=3F (internal zero kept), digit2 06, digit3 00.
REQ-028 Load A9F0 -> digit0 3F, digit1 40, digit2 6F, digit3 40; with i_lzb=1 digit3 not blanked.
REQ-029 Change i_digits with i_load=0 -> o_seg unchanged; i_load on terminal-tick cycle -> next edge shows advanced index with new data.
REQ-030 Assert rst while o_an=0100 -> next edge o_an=0000, o_seg=00; after release o_an=0001 for 4 cycles, o_seg=3F.
